// File: rtl/lsu_request_unit.sv
// Data-memory request unit: one load/store at a time, word-addressed byte-enabled port,
// misaligned halfword/word accesses optionally split into two aligned beats.
module lsu_request_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter bit SPLIT_EN      = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_addrmode,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [3:0]               mem_be,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);
    localparam int DW2 = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    function automatic logic [2:0] size_of(input logic [2:0] mode);
        case (mode[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic illegal_mode(input logic wr, input logic [2:0] mode);
        if (wr)
            return mode[2] | (mode == 3'b011);
        return (mode == 3'b011) | (mode == 3'b110) | (mode == 3'b111);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] mode,
                                                     input logic [DATA_WIDTH-1:0] v);
        case (mode)
            3'b000:  return {{(DATA_WIDTH-8){v[7]}}, v[7:0]};
            3'b100:  return {{(DATA_WIDTH-8){1'b0}}, v[7:0]};
            3'b001:  return {{(DATA_WIDTH-16){v[15]}}, v[15:0]};
            3'b101:  return {{(DATA_WIDTH-16){1'b0}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    state_t                   r_state;
    logic                     r_write;
    logic [2:0]               r_mode;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_beat0;
    logic                     r_split;
    logic                     r_err;

    logic [2:0]               w_req_size;
    logic                     w_req_split;
    logic                     w_req_err;
    logic                     w_accept;

    assign w_req_size  = size_of(req_addrmode);
    assign w_req_split = ({1'b0, req_address[1:0]} + w_req_size) > 3'd4;
    assign w_req_err   = illegal_mode(req_write, req_addrmode) | (w_req_split & ~SPLIT_EN);
    assign w_accept    = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_mode  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_beat0 <= '0;
            r_split <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write <= req_write;
                        r_mode  <= req_addrmode;
                        r_addr  <= req_address;
                        r_wdata <= req_wdata;
                        r_split <= w_req_split;
                        r_err   <= w_req_err;
                        r_state <= w_req_err ? RESP : ACC0;
                    end
                end
                ACC0: r_state <= r_split ? ACC1 : RESP;
                ACC1: begin
                    // Beat-0 read data arrives now; beat-1 data arrives in RESP.
                    if (!r_write)
                        r_beat0 <= mem_rdata;
                    r_state <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic [1:0]               w_off;
    logic [2:0]               w_size;
    logic [3:0]               w_size_mask;
    logic [7:0]               w_lanes;
    logic [DW2-1:0]           w_wshift;
    logic [DW2-1:0]           w_rshift;
    logic [DATA_WIDTH-1:0]    w_lo;
    logic [DATA_WIDTH-1:0]    w_hi;
    logic [ADDRESS_WIDTH-1:0] w_word_addr;
    logic                     w_acc0;
    logic                     w_acc1;

    assign w_off       = r_addr[1:0];
    assign w_size      = size_of(r_mode);
    assign w_size_mask = (w_size == 3'd1) ? 4'b0001 : ((w_size == 3'd2) ? 4'b0011 : 4'b1111);
    // Low nibble holds beat-0 lanes, high nibble the lanes spilling into beat 1.
    assign w_lanes     = {4'b0000, w_size_mask} << w_off;
    assign w_wshift    = {{DATA_WIDTH{1'b0}}, r_wdata} << {w_off, 3'b000};
    assign w_word_addr = {r_addr[ADDRESS_WIDTH-1:2], 2'b00};
    assign w_lo        = r_split ? r_beat0 : mem_rdata;
    assign w_hi        = r_split ? mem_rdata : '0;
    assign w_rshift    = {w_hi, w_lo} >> {w_off, 3'b000};

    assign w_acc0     = (r_state == ACC0) & ~rst;
    assign w_acc1     = (r_state == ACC1) & ~rst;
    assign req_ready  = (r_state == IDLE) & ~rst;
    assign mem_en     = w_acc0 | w_acc1;
    assign mem_we     = mem_en & r_write;
    assign mem_addr   = w_acc1 ? (w_word_addr + ADDRESS_WIDTH'(4)) : w_word_addr;
    assign mem_be     = w_acc0 ? w_lanes[3:0] : (w_acc1 ? w_lanes[7:4] : 4'b0000);
    assign mem_wdata  = !mem_we ? '0 :
                        (w_acc1 ? w_wshift[DW2-1:DATA_WIDTH] : w_wshift[DATA_WIDTH-1:0]);
    assign resp_valid = (r_state == RESP) & ~rst;
    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = (resp_valid & ~r_err & ~r_write) ?
                        extend(r_mode, w_rshift[DATA_WIDTH-1:0]) : '0;

endmodule

// File: tb/tb_lsu_request_unit.sv
// Bench for lsu_request_unit: byte-level reference model, bench-owned RAM, directed and random requests.
module tb_lsu_request_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_addrmode = 3'b000;
  logic [31:0] req_address = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] mem_rdata;

  logic        req_ready, resp_valid, resp_err, mem_en, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        ns_req_ready, ns_resp_valid, ns_resp_err, ns_mem_en, ns_mem_we;
  logic [31:0] ns_resp_rdata, ns_mem_addr, ns_mem_wdata;
  logic [3:0]  ns_mem_be;

  logic [31:0] mem [logic [31:0]];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_request_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addrmode(req_addrmode), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  lsu_request_unit #(.SPLIT_EN(1'b0)) u_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ns_req_ready),
    .req_write(req_write), .req_addrmode(req_addrmode), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(ns_resp_valid), .resp_err(ns_resp_err),
    .resp_rdata(ns_resp_rdata), .mem_en(ns_mem_en), .mem_we(ns_mem_we),
    .mem_addr(ns_mem_addr), .mem_be(ns_mem_be), .mem_wdata(ns_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] rdw(input logic [31:0] w);
    if (mem.exists(w)) return mem[w];
    return {w[15:0] ^ 16'h5A3C, w[31:16] ^ 16'hC3A5};
  endfunction

  function automatic logic [7:0] model_byte(input logic [31:0] a);
    logic [31:0] w;
    w = rdw({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{be[l]}};
    return m;
  endfunction

  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= rdw(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] o_rdata,
                        output logic [31:0] o_a1);
    int size, off, exp_lat, exp_nb, ns_lat_e, ns_nb_e, k;
    int nb, lat, ns_lat, ns_nb;
    bit ill, spl, ns_bad;
    logic [31:0] b, eval, exp_rd, w;
    logic [31:0] ea [2];
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];
    logic [31:0] ew [2];
    logic [31:0] ga [2];
    logic [3:0]  gbe [2];
    logic        gwe [2];
    logic [31:0] gwd [2];
    logic [31:0] nsa, nswd;
    logic [3:0]  nsbe;
    logic        nswe, gerr, ns_err;
    logic [31:0] grd, ns_rd;
    string tag;

    tag = $sformatf("%s m%0d a%h", wr ? "st" : "ld", mode, addr);
    size = (mode[1:0] == 2'b00) ? 1 : ((mode[1:0] == 2'b01) ? 2 : 4);
    off = int'(addr[1:0]);
    ill = wr ? (mode[2] || mode == 3'b011)
             : (mode == 3'b011 || mode == 3'b110 || mode == 3'b111);
    spl = (off + size) > 4;
    ea[0] = {addr[31:2], 2'b00};
    ea[1] = ea[0] + 32'd4;
    ebe[0] = 4'b0; ebe[1] = 4'b0;
    ewd[0] = 32'h0; ewd[1] = 32'h0;
    ew[0] = rdw(ea[0]); ew[1] = rdw(ea[1]);
    eval = 32'h0;
    for (int i = 0; i < size; i++) begin
      b = addr + 32'(i);
      k = (b[31:2] == addr[31:2]) ? 0 : 1;
      ebe[k][b[1:0]] = 1'b1;
      ewd[k][8*b[1:0] +: 8] = wd[8*i +: 8];
      if (wr && !ill) ew[k][8*b[1:0] +: 8] = wd[8*i +: 8];
      eval[8*i +: 8] = model_byte(b);
    end
    if (!mode[2] && size < 4 && eval[8*size-1])
      for (int j = size; j < 4; j++) eval[8*j +: 8] = 8'hFF;
    exp_rd = (ill || wr) ? 32'h0 : eval;
    exp_lat = ill ? 1 : (spl ? 3 : 2);
    exp_nb = ill ? 0 : (spl ? 2 : 1);
    ns_bad = ill || spl;
    ns_lat_e = ns_bad ? 1 : exp_lat;
    ns_nb_e = ns_bad ? 0 : 1;

    @(negedge clk);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addrmode = mode;
    req_address = addr; req_wdata = wd;
    @(posedge clk);
    nb = 0; lat = 0; ns_lat = 0; ns_nb = 0; gerr = 1'b0; ns_err = 1'b0;
    grd = 32'h0; ns_rd = 32'h0;
    nsa = 32'h0; nswd = 32'h0; nsbe = 4'h0; nswe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ga[i] = 32'h0; gbe[i] = 4'h0; gwe[i] = 1'b0; gwd[i] = 32'h0;
    end
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_en) begin
        if (nb < 2) begin
          ga[nb] = mem_addr; gbe[nb] = mem_be; gwe[nb] = mem_we; gwd[nb] = mem_wdata;
        end
        if (mem_we) begin
          w = rdw(mem_addr);
          for (int l = 0; l < 4; l++) if (mem_be[l]) w[8*l +: 8] = mem_wdata[8*l +: 8];
          mem[mem_addr] = w;
        end
        nb++;
      end
      if (ns_mem_en) begin
        nsa = ns_mem_addr; nsbe = ns_mem_be; nswe = ns_mem_we; nswd = ns_mem_wdata;
        ns_nb++;
      end
      if (ns_resp_valid && ns_lat == 0) begin
        ns_lat = c; ns_err = ns_resp_err; ns_rd = ns_resp_rdata;
      end
      if (resp_valid) begin
        lat = c; gerr = resp_err; grd = resp_rdata;
      end
      if (c == 1) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addrmode = 3'($urandom_range(0, 7));
        req_address = $urandom;
        req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;

    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " err"}, 32'(gerr), 32'(ill));
    chk({tag, " rdata"}, grd, exp_rd);
    chk({tag, " beats"}, 32'(nb), 32'(exp_nb));
    for (int i = 0; i < exp_nb; i++) begin
      chk($sformatf("%s b%0d addr", tag, i), ga[i], ea[i]);
      chk($sformatf("%s b%0d be", tag, i), 32'(gbe[i]), 32'(ebe[i]));
      chk($sformatf("%s b%0d we", tag, i), 32'(gwe[i]), 32'(wr));
      if (wr)
        chk($sformatf("%s b%0d wdata", tag, i), gwd[i] & lanes(ebe[i]), ewd[i]);
      else
        chk($sformatf("%s b%0d wdata", tag, i), gwd[i], 32'h0);
    end
    if (wr && !ill) begin
      chk({tag, " mem0"}, rdw(ea[0]), ew[0]);
      if (spl) chk({tag, " mem1"}, rdw(ea[1]), ew[1]);
    end
    chk({tag, " ns latency"}, 32'(ns_lat), 32'(ns_lat_e));
    chk({tag, " ns err"}, 32'(ns_err), 32'(ns_bad));
    chk({tag, " ns beats"}, 32'(ns_nb), 32'(ns_nb_e));
    if (ns_bad) begin
      chk({tag, " ns rdata"}, ns_rd, 32'h0);
    end else begin
      chk({tag, " ns addr"}, nsa, ea[0]);
      chk({tag, " ns be"}, 32'(nsbe), 32'(ebe[0]));
      chk({tag, " ns we"}, 32'(nswe), 32'(wr));
      chk({tag, " ns rdata"}, ns_rd, exp_rd);
    end

    if (lat == 0) begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end else begin
      @(negedge clk);
      chk({tag, " ready after"}, 32'(req_ready), 32'd1);
    end
    o_rdata = grd;
    o_a1 = ga[1];
  endtask

  initial begin
    logic [31:0] rd, a1, addr, wd;
    logic [2:0]  mode;
    logic        wr;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready out of reset", 32'(req_ready), 32'd1);

    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, rd, a1);
    chk("sw word", rdw(32'h100), 32'hDEADBEEF);
    chk("sw rdata", rd, 32'h0);

    mem[32'h100] = 32'h80112233;
    do_req(1'b0, 3'b000, 32'h103, 32'h0, rd, a1);
    chk("lb 0x103", rd, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h103, 32'h0, rd, a1);
    chk("lbu 0x103", rd, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h102, 32'h0, rd, a1);
    chk("lh 0x102", rd, 32'hFFFF8011);

    mem[32'hFC] = 32'h44332211;
    mem[32'h100] = 32'h88776655;
    do_req(1'b0, 3'b010, 32'hFE, 32'h0, rd, a1);
    chk("lw 0xfe", rd, 32'h66554433);
    chk("lw 0xfe beat1", a1, 32'h100);

    do_req(1'b1, 3'b001, 32'hFF, 32'h0000AABB, rd, a1);
    chk("sh 0xff lo word", rdw(32'hFC), 32'hBB332211);
    chk("sh 0xff hi word", rdw(32'h100), 32'h887766AA);

    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, rd, a1);
    chk("lw wrap beat1", a1, 32'h0);
    do_req(1'b0, 3'b011, 32'h100, 32'h0, rd, a1);
    do_req(1'b1, 3'b100, 32'h104, 32'h12345678, rd, a1);
    do_req(1'b0, 3'b010, 32'h101, 32'h0, rd, a1);

    // Reset during the second beat of a split load
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addrmode = 3'b010; req_address = 32'hFE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst-test acc0 en", 32'(mem_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst-test acc1 en", 32'(mem_en), 32'd0);
    chk("rst-test acc1 resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst-test ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("rst-test no resp", 32'(resp_valid), 32'd0);
      chk("rst-test no access", 32'(mem_en), 32'd0);
    end
    do_req(1'b0, 3'b010, 32'h100, 32'h0, rd, a1);
    chk("lw after rst", rd, 32'h887766AA);

    for (int n = 0; n < 200; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        mode = 3'($urandom_range(0, 7));
      else
        mode = wr ? 3'($urandom_range(0, 2)) : ((($urandom_range(0, 1)) == 0) ?
               3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
      case ($urandom_range(0, 2))
        0:       addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
        1:       addr = 32'hFFFFFFF8 + 32'(4 * $urandom_range(0, 1));
        default: addr = 32'(4 * $urandom_range(0, 3));
      endcase
      addr = addr + 32'($urandom_range(0, 3));
      wd = $urandom;
      do_req(wr, mode, addr, wd, rd, a1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_request_unit.md
Name: lsu_request_unit

Overview:
- Core-side initiator for the data-memory port: accepts one load/store per request from the execute stage and drives a word-addressed, byte-enabled memory.
- Returns load data, sign- or zero-extended per funct3, with a one-cycle response pulse.
- Handles misaligned halfword/word accesses by splitting them into two aligned beats.
- Sits between the core's memory stage and the RAM.

Parameters:
- ADDRESS_WIDTH, 32, byte address width; beat-1 address wraps modulo 2^ADDRESS_WIDTH.
- DATA_WIDTH, 32, data and word width; only 32 is supported, and the 4 byte lanes are fixed.
- SPLIT_EN, 1, 1 = misaligned accesses are split into two beats; 0 = misaligned accesses return an error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addrmode  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_address  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; illegal mode, or misaligned with SPLIT_EN=0.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write when mem_en.
- mem_addr  out  ADDRESS_WIDTH  word-aligned address; bits [1:0] always 0.
- mem_be  out  4  byte enables, little-endian lanes.
- mem_wdata  out  DATA_WIDTH  lane-aligned write data.
- mem_rdata  in  DATA_WIDTH  read word, valid the cycle after a read access.

Behaviour:
- States: IDLE, ACC0, ACC1, RESP.
- Handshake:
  - req_ready = (state==IDLE) & !rst.
  - Accept on req_valid & req_ready; latch write, mode, address, wdata.
- Legality:
  - Loads: 011, 110, 111 are illegal.
  - Stores: any mode with bit 2 set, or 011, is illegal.
  - Size 1/2/4 bytes; off = address[1:0].
  - Split when off + size > 4.
- Transitions after accept at cycle T:
  - Illegal, or split needed with SPLIT_EN=0: go to RESP; resp_valid=1, resp_err=1 at T+1. No memory access.
  - Non-split: ACC0 at T+1, RESP at T+2.
  - Split: ACC0 at T+1, ACC1 at T+2, RESP at T+3.
  - RESP always returns to IDLE. One request in flight; no response backpressure.
- ACC0:
  - mem_en=1, mem_addr = address & ~3.
  - mem_be covers bytes off .. min(off+size,4)-1.
  - Store data is req_wdata shifted left by 8*off, truncated to 32 bits.
- ACC1:
  - mem_en=1, mem_addr = (address & ~3) + 4, wrapping (0xFFFFFFFC -> 0x0).
  - mem_be covers bytes 0 .. off+size-5.
  - Store data is the remaining high bytes of req_wdata, starting at lane 0.
  - For loads, ACC1 also captures the beat-0 mem_rdata into an internal register.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - Loads: window = {mem_rdata (beat 1 data, or 0 if not split), beat0}, where beat0 is the register captured in ACC1 for split loads and mem_rdata itself for non-split loads.
  - Shift the window right by 8*off and take size bytes.
  - B/H are sign-extended; BU/HU are zero-extended.
- mem_en, mem_we and mem_be are 0 outside ACC0/ACC1.
- mem_wdata is 0 for loads.
- Reset:
  - While rst is high: state <= IDLE; req_ready, resp_valid, resp_err and mem_en are 0 that same cycle (outputs gated by rst); resp_rdata = 0; internal registers cleared.
  - Reset mid-operation abandons the request; no further beats and no response. A split store may be left half-written; this is accepted behaviour.
- req_valid while not ready is ignored and not queued.
- Inputs are sampled only at accept; later changes have no effect.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF at T -> T+1: mem_en=1, we=1, addr 0x100, be=1111, wdata 0xDEADBEEF. T+2: resp_valid=1, err=0, rdata=0.
- mem[0x100]=0x80112233:
  - LB 0x103 -> addr 0x100, be=1000; resp at T+2, rdata 0xFFFFFF80.
  - LBU 0x103 -> rdata 0x00000080.
  - LH 0x102 -> rdata 0xFFFF8011.
- mem[0xFC]=0x44332211, mem[0x100]=0x88776655; LW 0xFE -> T+1 read 0xFC be=1100; T+2 read 0x100 be=0011; T+3 rdata 0x66554433, err=0.
- SH 0xFF, data 0x0000AABB -> T+1: addr 0xFC, be=1000, wdata 0xBB000000. T+2: addr 0x100, be=0001, wdata 0x000000AA. T+3: resp_valid=1.
- LW 0xFFFFFFFE -> beat-1 addr 0x00000000. Illegal load mode 011 -> no mem_en; T+1 resp_valid=1, err=1. SPLIT_EN=0 with LW 0x101 -> same error response.
- rst asserted in the ACC1 cycle of a split load -> mem_en=0 that cycle, no resp_valid. req_ready=1 the cycle after rst falls. A new LW 0x100 then completes normally.
